regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file for the RISC-V core, with two read ports and one write port.
//  Adds an issue scoreboard (per-register busy bits) so decode can stall on pending writes.
//  Adds a handshaked dump engine that streams every register out for debug/board readout.
//  Sits between decode (read/issue) and writeback (write); replaces the fixed 32x32 file.
// PARAMETERS
//  XLEN      32  data width in bits
//  NREGS     32  number of registers; power of two, >=2
//  ZERO_REG  1   1: index 0 reads as zero and ignores writes; 0: index 0 is an ordinary register
//  TAP_INDEX 31  register mirrored on tap_data (board LEDs/debug)
//  IDX_W     $clog2(NREGS), derived, not overridable
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset      in   1      asynchronous, active-high reset
//  wr_en      in   1      writeback write strobe
//  wr_index   in   IDX_W  write address
//  wr_data    in   XLEN   write data
//  rd_en1     in   1      read port 1 enable
//  rd_index1  in   IDX_W  read port 1 address
//  rd_data1   out  XLEN   read port 1 data (combinational)
//  rd_en2     in   1      read port 2 enable
//  rd_index2  in   IDX_W  read port 2 address
//  rd_data2   out  XLEN   read port 2 data (combinational)
//  iss_en     in   1      instruction issued that will write iss_index
//  iss_index  in   IDX_W  destination of the issued instruction
//  stall      out  1      an enabled source register is busy
//  dump_start in   1      one-cycle pulse requesting a full register dump
//  dump_ready in   1      consumer accepts the current dump beat
//  dump_valid out  1      dump beat valid
//  dump_index out  IDX_W  index of the current dump beat
//  dump_data  out  XLEN   contents of the current dump beat
//  dump_done  out  1      one-cycle pulse after the last beat is accepted
//  tap_data   out  XLEN   registers[TAP_INDEX]
// BEHAVIOUR
//  Reset: asynchronous. All registers = 0, busy = 0, dump FSM = IDLE, dump pointer = 0.
//   All outputs read 0 during reset: rd_data*, stall, dump_valid, dump_done, tap_data.
//   Reset asserted mid-dump aborts the dump; no dump_done pulse.
//  Write: on a clock edge with wr_en=1, registers[wr_index] <= wr_data.
//   When ZERO_REG=1, a write to index 0 is dropped.
//  Read: rd_dataN = rd_enN ? registers[rd_indexN] : 0, zero latency.
//   When ZERO_REG=1, index 0 always reads 0.
//  Scoreboard: busy[i] is set on an edge with iss_en and iss_index=i, and cleared on an edge with wr_en and wr_index=i.
//   If set and clear hit the same index in the same cycle, set wins (the newer instruction is pending).
//   Index 0 is never busy when ZERO_REG=1.
//   stall = (rd_en1 & busy[rd_index1]) | (rd_en2 & busy[rd_index2]), combinational, evaluated on the current busy bits.
//  Dump FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: dump_start=1 -> RUN, ptr=0. dump_start is ignored in RUN and DONE.
//   RUN: dump_valid=1, dump_index=ptr, dump_data=registers[ptr] (live value, no snapshot).
//    On dump_valid & dump_ready: if ptr=NREGS-1 go to DONE, else ptr++.
//    dump_ready low holds the beat stable.
//   DONE: dump_done=1 for exactly one cycle, then IDLE.
//   dump_valid=0 outside RUN. dump_index/dump_data = 0 outside RUN.
//   The dump has no effect on the read/write ports or the scoreboard.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: when wr_en=1 and wr_index=rd_indexN, rd_dataN returns wr_data in the same cycle (write-first).
//   This applies only if rd_enN=1 and the write is not dropped by ZERO_REG.
//   In the same case, stall ignores busy[wr_index], because the value is being delivered.
//  REGFILE_BYPASS_EN undefined: reads return the array value only; the new value is visible from the cycle after the write.
// TESTING
//  T1 reset: write x5=0x1234, assert reset -> rd_data1 of x5 = 0 and tap_data = 0 immediately, before any clock edge.
//  T2 zero reg: write x0=0xFFFFFFFF, then read x0 -> 0.
//     Same test with ZERO_REG=0 -> 0xFFFFFFFF.
//  T3 scoreboard: issue x7; next cycle read x7 -> stall=1.
//     Write x7=0xA5 -> stall=0 the cycle after.
//     Issue and write x7 on the same edge -> busy stays 1.
//  T4 bypass: read x3 while writing x3=0xCAFE -> rd_data=0xCAFE with the macro, old value without it.
//  T5 dump: start a dump with registers preset to i*4 and dump_ready toggling 1/0.
//     -> 32 beats, index 0..31, data i*4, dump_done pulses once, dump_start ignored mid-run.
//  T6 abort: reset at beat 10 -> dump_valid=0, no dump_done.
//     A new dump_start after reset begins again at index 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with two read ports, one write port, issue scoreboard and a handshaked dump engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports (write-first).
module regfile_sb #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned ZERO_REG  = 1,
    parameter int unsigned TAP_INDEX = 31,
    localparam int unsigned IDX_W    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             rd_en1,
    input  logic [IDX_W-1:0] rd_index1,
    output logic [XLEN-1:0]  rd_data1,
    input  logic             rd_en2,
    input  logic [IDX_W-1:0] rd_index2,
    output logic [XLEN-1:0]  rd_data2,
    input  logic             iss_en,
    input  logic [IDX_W-1:0] iss_index,
    output logic             stall,
    input  logic             dump_start,
    input  logic             dump_ready,
    output logic             dump_valid,
    output logic [IDX_W-1:0] dump_index,
    output logic [XLEN-1:0]  dump_data,
    output logic             dump_done,
    output logic [XLEN-1:0]  tap_data
);

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_RUN  = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    dump_state_e      state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             wr_ok;
    logic             stall1, stall2;

    // Writes to x0 are discarded when it is hardwired to zero.
    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_index == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_index] <= wr_data;
        end
    end

    // Scoreboard: a same-cycle issue overrides the writeback clear.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_index] = 1'b0;
        end
        if (iss_en) begin
            busy_d[iss_index] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = rd_en1 && wr_ok && (wr_index == rd_index1) && !reset;
    assign byp2 = rd_en2 && wr_ok && (wr_index == rd_index2) && !reset;
`endif

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        stall1   = rd_en1 && busy_q[rd_index1];
        stall2   = rd_en2 && busy_q[rd_index2];
        if (rd_en1 && !((ZERO_REG != 0) && (rd_index1 == '0))) begin
            rd_data1 = regs_q[rd_index1];
        end
        if (rd_en2 && !((ZERO_REG != 0) && (rd_index2 == '0))) begin
            rd_data2 = regs_q[rd_index2];
        end
`ifdef REGFILE_BYPASS_EN
        if (byp1) begin
            rd_data1 = wr_data;
            stall1   = 1'b0;
        end
        if (byp2) begin
            rd_data2 = wr_data;
            stall2   = 1'b0;
        end
`endif
    end

    assign stall    = stall1 || stall2;
    assign tap_data = regs_q[IDX_W'(TAP_INDEX)];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DUMP_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Dump engine: one beat per register, data is the live register value.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        dump_valid = 1'b0;
        dump_index = '0;
        dump_data  = '0;
        dump_done  = 1'b0;
        case (state_q)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_d = DUMP_RUN;
                    ptr_d   = '0;
                end
            end
            DUMP_RUN: begin
                dump_valid = 1'b1;
                dump_index = ptr_q;
                dump_data  = regs_q[ptr_q];
                if (dump_ready) begin
                    if (ptr_q == IDX_W'(NREGS - 1)) begin
                        state_d = DUMP_DONE;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
            end
            DUMP_DONE: begin
                dump_done = 1'b1;
                state_d   = DUMP_IDLE;
                ptr_d     = '0;
            end
            default: begin
                state_d = DUMP_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, randomized traffic against an array model,
// and hand sequences for reset, dump streaming and dump abort.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, rd_en1, rd_en2, iss_en, dump_start, dump_ready;
    logic [4:0]  wr_index, rd_index1, rd_index2, iss_index;
    logic [31:0] wr_data;
    logic [31:0] rd_data1, rd_data2, dump_data, tap_data;
    logic        stall, dump_valid, dump_done;
    logic [4:0]  dump_index;
    logic [31:0] z_rd_data1, z_rd_data2, z_dump_data, z_tap_data;
    logic        z_stall, z_dump_valid, z_dump_done;
    logic [4:0]  z_dump_index;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .TAP_INDEX(31)) u_dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .rd_en1(rd_en1), .rd_index1(rd_index1), .rd_data1(rd_data1),
        .rd_en2(rd_en2), .rd_index2(rd_index2), .rd_data2(rd_data2),
        .iss_en(iss_en), .iss_index(iss_index), .stall(stall),
        .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
        .dump_index(dump_index), .dump_data(dump_data), .dump_done(dump_done),
        .tap_data(tap_data)
    );

    // Same stimulus, x0 as an ordinary register.
    regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(0), .TAP_INDEX(31)) u_dut0 (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .rd_en1(rd_en1), .rd_index1(rd_index1), .rd_data1(z_rd_data1),
        .rd_en2(rd_en2), .rd_index2(rd_index2), .rd_data2(z_rd_data2),
        .iss_en(iss_en), .iss_index(iss_index), .stall(z_stall),
        .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(z_dump_valid),
        .dump_index(z_dump_index), .dump_data(z_dump_data), .dump_done(z_dump_done),
        .tap_data(z_tap_data)
    );

    // Reference model: register contents and pending-destination flags.
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    typedef struct {
        logic        w;
        logic [4:0]  wi;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ii;
        logic        re;
        logic [4:0]  ri;
        logic [31:0] exp_rd;
        logic        exp_stall;
    } vec_t;

    localparam int NV = 13;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_busy = 32'h0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_clear();
        end else begin
            if (wr_en && wr_index != 5'd0) m_regs[wr_index] = wr_data;
            if (wr_en) m_busy[wr_index] = 1'b0;
            if (iss_en && iss_index != 5'd0) m_busy[iss_index] = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] idx);
        if (!en || idx == 5'd0) return 32'h0;
        if (BYP && wr_en && wr_index == idx) return wr_data;
        return m_regs[idx];
    endfunction

    function automatic logic exp_port_stall(input logic en, input logic [4:0] idx);
        return en && m_busy[idx] && !(BYP && wr_en && wr_index == idx && idx != 5'd0);
    endfunction

    function automatic logic [4:0] rnd_idx();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_index = 5'd0; wr_data = 32'h0;
        rd_en1 = 1'b0; rd_index1 = 5'd0; rd_en2 = 1'b0; rd_index2 = 5'd0;
        iss_en = 1'b0; iss_index = 5'd0; dump_start = 1'b0; dump_ready = 1'b0;
    endtask

    initial begin
        int k, done_cnt, post, cyc;
        reset = 1'b1;
        idle_inputs();
        model_clear();
        rd_en1 = 1'b1; rd_index1 = 5'd5; rd_en2 = 1'b1; rd_index2 = 5'd31;
        #1;
        chk("reset_rd1", rd_data1, 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_dump_valid", 32'(dump_valid), 32'h0);
        chk("reset_tap", tap_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();

        vec[0]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b1, 5'd0, 32'h0, 1'b0};
        vec[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h0, 1'b0};
        vec[2]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, 32'h0, 1'b0};
        vec[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h0, 1'b1};
        vec[4]  = '{1'b1, 5'd7, 32'hA5, 1'b0, 5'd0, 1'b1, 5'd7, BYP ? 32'hA5 : 32'h0, !BYP};
        vec[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hA5, 1'b0};
        vec[6]  = '{1'b1, 5'd7, 32'hB6, 1'b1, 5'd7, 1'b1, 5'd7, BYP ? 32'hB6 : 32'hA5, 1'b0};
        vec[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hB6, 1'b1};
        vec[8]  = '{1'b1, 5'd7, 32'hC7, 1'b0, 5'd0, 1'b1, 5'd7, BYP ? 32'hC7 : 32'hB6, !BYP};
        vec[9]  = '{1'b1, 5'd3, 32'h1111, 1'b0, 5'd0, 1'b1, 5'd7, 32'hC7, 1'b0};
        vec[10] = '{1'b1, 5'd3, 32'hCAFE, 1'b0, 5'd0, 1'b1, 5'd3, BYP ? 32'hCAFE : 32'h1111, 1'b0};
        vec[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hCAFE, 1'b0};
        vec[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 32'h0, 1'b0};

        for (int i = 0; i < NV; i++) begin
            wr_en = vec[i].w; wr_index = vec[i].wi; wr_data = vec[i].wd;
            iss_en = vec[i].iss; iss_index = vec[i].ii;
            rd_en1 = vec[i].re; rd_index1 = vec[i].ri;
            @(negedge clk);
            chk($sformatf("vec%0d_rd1", i), rd_data1, vec[i].exp_rd);
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vec[i].exp_stall));
            chk($sformatf("vec%0d_rd2", i), rd_data2, 32'h0);
            tick();
        end

        idle_inputs();
        rd_en1 = 1'b1; rd_index1 = 5'd0;
        @(negedge clk);
        chk("x0_hardwired", rd_data1, 32'h0);
        chk("x0_ordinary", z_rd_data1, 32'hFFFF_FFFF);
        tick();

        for (int i = 0; i < 300; i++) begin
            wr_en = 1'($urandom_range(0, 1)); wr_index = rnd_idx(); wr_data = $urandom;
            iss_en = 1'($urandom_range(0, 1)); iss_index = rnd_idx();
            rd_en1 = 1'($urandom_range(0, 3) != 0); rd_index1 = rnd_idx();
            rd_en2 = 1'($urandom_range(0, 3) != 0); rd_index2 = rnd_idx();
            @(negedge clk);
            chk("rnd_rd1", rd_data1, exp_rd(rd_en1, rd_index1));
            chk("rnd_rd2", rd_data2, exp_rd(rd_en2, rd_index2));
            chk("rnd_stall", 32'(stall),
                32'(exp_port_stall(rd_en1, rd_index1) || exp_port_stall(rd_en2, rd_index2)));
            chk("rnd_tap", tap_data, m_regs[31]);
            chk("rnd_dump_valid", 32'(dump_valid), 32'h0);
            tick();
        end

        idle_inputs();
        wr_en = 1'b1; wr_index = 5'd5; wr_data = 32'h1234;
        tick();
        wr_index = 5'd31; wr_data = 32'h77;
        tick();
        wr_en = 1'b0; rd_en1 = 1'b1; rd_index1 = 5'd5;
        #1;
        chk("pre_reset_rd1", rd_data1, 32'h1234);
        chk("pre_reset_tap", tap_data, 32'h77);
        wr_en = 1'b1; wr_index = 5'd5; wr_data = 32'hDEAD;
        reset = 1'b1;
        #1;
        chk("async_reset_rd1", rd_data1, 32'h0);
        chk("async_reset_tap", tap_data, 32'h0);
        tick();
        reset = 1'b0;
        idle_inputs();

        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_index = 5'(i); wr_data = 32'(i * 4);
            tick();
        end
        idle_inputs();

        dump_start = 1'b1;
        @(negedge clk);
        chk("dump_idle_valid", 32'(dump_valid), 32'h0);
        tick();
        dump_start = 1'b0;
        k = 0; done_cnt = 0; post = 0; cyc = 0;
        while ((k < 32 || post < 3) && cyc < 400) begin
            dump_ready = (cyc % 2 == 0);
            dump_start = (k < 32) && (cyc % 5 == 2);
            @(negedge clk);
            if (k < 32) begin
                chk("dump_valid", 32'(dump_valid), 32'h1);
                chk("dump_index", 32'(dump_index), 32'(k));
                chk("dump_data", dump_data, 32'(k * 4));
                chk("dump_done_early", 32'(dump_done), 32'h0);
                if (dump_ready) k++;
            end else begin
                chk("dump_post_valid", 32'(dump_valid), 32'h0);
                chk("dump_post_index", 32'(dump_index), 32'h0);
                if (dump_done) done_cnt++;
                post++;
            end
            tick();
            cyc++;
        end
        chk("dump_finished", 32'(k == 32 && post == 3), 32'h1);
        chk("dump_done_count", 32'(done_cnt), 32'h1);

        idle_inputs();
        dump_ready = 1'b1; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            chk("abort_index", 32'(dump_index), 32'(k));
            k++;
            tick();
        end
        @(negedge clk);
        chk("abort_beat10", 32'(dump_index), 32'd10);
        reset = 1'b1;
        #1;
        chk("abort_valid", 32'(dump_valid), 32'h0);
        chk("abort_index0", 32'(dump_index), 32'h0);
        chk("abort_done", 32'(dump_done), 32'h0);
        tick();
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dump_done || dump_valid) done_cnt++;
            tick();
        end
        chk("abort_quiet", 32'(done_cnt), 32'h0);
        dump_start = 1'b1;
        @(negedge clk);
        chk("restart_idle", 32'(dump_valid), 32'h0);
        tick();
        dump_start = 1'b0;
        @(negedge clk);
        chk("restart_valid", 32'(dump_valid), 32'h1);
        chk("restart_index", 32'(dump_index), 32'h0);
        chk("restart_data", dump_data, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
